instruction_fetch_unit: RTL
===========================

// Module: instruction_fetch_unit
// PURPOSE
//  Instruction-fetch stage upstream of Ram's fetch port. Holds the program counter and drives
//  fetch_address. Ram returns fetch_out combinationally from that address.
//  Captures each fetched word into a one-entry instruction register and offers it to decode
//  over a valid/ready handshake. Supports branch redirect/flush and stops on a HALT opcode.
// PARAMETERS
//  DATA_SIZE     32        instruction word width; matches Ram DATA_SIZE
//  ADDRESS_SIZE  16        word-address width; matches Ram ADDRESS_SIZE
//  RESET_PC      16'd0     PC value loaded on reset
//  HALT_OPCODE   4'b1111   value of instr[DATA_SIZE-1 -: 4] that halts fetching
// PORTS
//  clk            in   1             single clock, rising edge
//  reset_n        in   1             asynchronous reset, active-low
//  enable         in   1             fetch permitted while high
//  fetch_address  out  ADDRESS_SIZE  word address to Ram; equals pc, combinational
//  fetch_out      in   DATA_SIZE     instruction word from Ram at fetch_address, same cycle
//  branch_taken   in   1             redirect request from execute
//  branch_target  in   ADDRESS_SIZE  new PC when branch_taken
//  instr_out      out  DATA_SIZE     registered instruction offered to decode
//  instr_pc       out  ADDRESS_SIZE  address instr_out was fetched from
//  instr_valid    out  1             instr_out holds an unconsumed instruction
//  instr_ready    in   1             decode accepts instr_out this cycle
//  halted         out  1             HALT instruction captured; fetch stopped
// BEHAVIOUR
//  Reset (reset_n low, async, any time incl. mid-fetch):
//   - pc=RESET_PC, instr_out=0, instr_pc=0, instr_valid=0, halted=0, state=IDLE.
//   - Any held instruction is discarded.
//  FSM states:
//   - IDLE: no captures. Goes to RUN on a clk edge with enable=1.
//   - RUN: fetches and captures.
//   - HALT: terminal. Exits only through reset.
//  Accept: instr_valid && instr_ready at the edge. Clears instr_valid unless a capture happens at the same edge.
//  Capture, in RUN with enable=1 and (!instr_valid || instr_ready), no branch:
//   - instr_out<=fetch_out, instr_pc<=pc, instr_valid<=1, pc<=pc+1.
//   - Throughput: one instruction per cycle under continuous ready.
//   - Latency: first valid instr_out one edge after entering RUN (RUN entry edge, then capture edge).
//  Stall:
//   - instr_valid=1 and instr_ready=0: instr_out, instr_pc and pc hold. No capture.
//   - enable=0 in RUN: no captures and pc holds. Accept still clears valid. State stays RUN.
//  Branch, branch_taken=1 in RUN, highest priority:
//   - pc<=branch_target and instr_valid<=0 (flush). No capture that edge.
//   - Applies regardless of enable or instr_ready.
//   - branch_taken is ignored in IDLE and HALT.
//  Halt:
//   - Trigger: a capture whose fetch_out[DATA_SIZE-1 -: 4]==HALT_OPCODE.
//   - That capture is presented normally (instr_valid=1). pc is NOT incremented.
//   - state<=HALT, halted<=1 at the same edge.
//   - In HALT the pending HALT instr remains until accepted, then instr_valid=0 permanently. No further captures.
//  Wrap-around: pc+1 wraps modulo 2^ADDRESS_SIZE (16'hFFFF -> 16'h0000). No flag.
//  Simultaneous branch and HALT capture at one edge: branch wins and the HALT word is not captured.
// TESTING
//  1. Reset, Ram words 0..3 preloaded, enable=1, ready=1: instr_pc 0,1,2,3 on consecutive cycles with matching words.
//  2. Hold ready=0 for 3 cycles while valid: instr_out/instr_pc/fetch_address frozen. ready=1 -> sequence resumes without skip.
//  3. branch_taken=1, target=16'h0040, with valid instr pending: next edge valid=0 and fetch_address=0x40. Following edge instr_pc=0x40.
//  4. Word at addr 2 = 32'hF000_0000: halted=1 after capture of addr 2, pc stays 2. After accept, valid=0 for 10 cycles.
//  5. pc=16'hFFFF, capture: next fetch_address=16'h0000.
//  6. Assert reset_n low between edges mid-run: outputs clear immediately (no clk edge). Release + enable restarts at RESET_PC.

Source files
------------

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, reads the instruction memory combinationally and
// presents each fetched word to decode through a one-entry valid/ready register.
module instruction_fetch_unit #(
  parameter int                      DATA_SIZE    = 32,
  parameter int                      ADDRESS_SIZE = 16,
  parameter logic [ADDRESS_SIZE-1:0] RESET_PC     = '0,
  parameter logic [3:0]              HALT_OPCODE  = 4'b1111
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    enable,
  output logic [ADDRESS_SIZE-1:0] fetch_address,
  input  logic [DATA_SIZE-1:0]    fetch_out,
  input  logic                    branch_taken,
  input  logic [ADDRESS_SIZE-1:0] branch_target,
  output logic [DATA_SIZE-1:0]    instr_out,
  output logic [ADDRESS_SIZE-1:0] instr_pc,
  output logic                    instr_valid,
  input  logic                    instr_ready,
  output logic                    halted
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t                  state_reg, state_next;
  logic [ADDRESS_SIZE-1:0] pc_reg, pc_next;
  logic [DATA_SIZE-1:0]    instr_reg, instr_next;
  logic [ADDRESS_SIZE-1:0] instr_pc_reg, instr_pc_next;
  logic                    valid_reg, valid_next;

  logic in_run;
  logic redirect;
  logic capture;
  logic accept;
  logic is_halt_word;

  // A branch pre-empts any capture at the same edge, including a HALT word.
  assign in_run       = (state_reg == RUN);
  assign redirect     = in_run && branch_taken;
  assign capture      = in_run && enable && !branch_taken && (!valid_reg || instr_ready);
  assign accept       = valid_reg && instr_ready;
  assign is_halt_word = (fetch_out[DATA_SIZE-1 -: 4] == HALT_OPCODE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg    <= IDLE;
      pc_reg       <= RESET_PC;
      instr_reg    <= '0;
      instr_pc_reg <= '0;
      valid_reg    <= 1'b0;
    end else begin
      state_reg    <= state_next;
      pc_reg       <= pc_next;
      instr_reg    <= instr_next;
      instr_pc_reg <= instr_pc_next;
      valid_reg    <= valid_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (enable) state_next = RUN;
      RUN:     if (capture && is_halt_word) state_next = HALT;
      HALT:    state_next = HALT;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    pc_next       = pc_reg;
    instr_next    = instr_reg;
    instr_pc_next = instr_pc_reg;
    valid_next    = valid_reg;
    if (redirect) begin
      pc_next    = branch_target;
      valid_next = 1'b0;
    end else if (capture) begin
      instr_next    = fetch_out;
      instr_pc_next = pc_reg;
      valid_next    = 1'b1;
      // The PC parks on a HALT word instead of advancing past it.
      if (!is_halt_word) pc_next = pc_reg + 1'b1;
    end else if (accept) begin
      valid_next = 1'b0;
    end
  end

  always_comb begin
    fetch_address = pc_reg;
    instr_out     = instr_reg;
    instr_pc      = instr_pc_reg;
    instr_valid   = valid_reg;
    halted        = (state_reg == HALT);
  end

endmodule
